// File: rtl/led_pattern_gen.sv
// N-channel LED pattern generator: off / on / blink / PWM breathe per channel,
// all driven from one shared prescaled tick so mode changes land cleanly.
module led_pattern_gen #(
  parameter int NUM_CH     = 3,
  parameter int PRESCALE   = 10000,
  parameter int BLINK_HALF = 50,
  parameter int PWM_BITS   = 4,
  parameter int STAGGER    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2*NUM_CH-1:0]   sel,
  output logic [NUM_CH-1:0]     led,
  output logic                  tick
);

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [PRESC_W-1:0]          presc_cnt, presc_nxt;
  logic [BLINK_W-1:0]          blink_cnt, blink_cnt_nxt;
  logic                        blink_ph, blink_ph_nxt;
  logic [PWM_BITS-1:0]         pwm_cnt, pwm_nxt;
  logic [PWM_BITS-1:0]         duty, duty_nxt;
  dir_e                        dir, dir_nxt;
  logic [NUM_CH-1:0][1:0]      mode_q, mode_nxt;
  logic [NUM_CH-1:0]           led_nxt;
  logic                        pwm_on;

  assign tick   = en && (presc_cnt == PRESC_LAST);
  assign pwm_on = (pwm_cnt < duty);

  // NOTE: every signal gets its hold value first so no path through this block
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    presc_nxt     = presc_cnt;
    blink_cnt_nxt = blink_cnt;
    blink_ph_nxt  = blink_ph;
    pwm_nxt       = pwm_cnt;
    duty_nxt      = duty;
    dir_nxt       = dir;
    mode_nxt      = mode_q;
    led_nxt       = '0;

    if (en) begin
      presc_nxt = (presc_cnt == PRESC_LAST) ? '0 : presc_cnt + 1'b1;
      pwm_nxt   = pwm_cnt + 1'b1;

      if (tick) begin
        for (int i = 0; i < NUM_CH; i++) mode_nxt[i] = sel[2*i +: 2];

        if (blink_cnt == BLINK_LAST) begin
          blink_cnt_nxt = '0;
          blink_ph_nxt  = ~blink_ph;
        end else begin
          blink_cnt_nxt = blink_cnt + 1'b1;
        end

        // Endpoints turn around in the same tick so the ramp never repeats MAX or 0.
        unique case (dir)
          DIR_UP: begin
            if (duty == DUTY_MAX) begin
              dir_nxt  = DIR_DOWN;
              duty_nxt = duty - 1'b1;
            end else begin
              duty_nxt = duty + 1'b1;
            end
          end
          DIR_DOWN: begin
            if (duty == '0) begin
              dir_nxt  = DIR_UP;
              duty_nxt = duty + 1'b1;
            end else begin
              duty_nxt = duty - 1'b1;
            end
          end
          default: dir_nxt = DIR_UP;
        endcase
      end

      // Decode uses the mode already latched; a newly loaded mode shows one edge later.
      for (int i = 0; i < NUM_CH; i++) begin
        case (mode_e'(mode_q[i]))
          MODE_OFF:   led_nxt[i] = 1'b0;
          MODE_ON:    led_nxt[i] = 1'b1;
          MODE_BLINK: led_nxt[i] = blink_ph ^ ((STAGGER != 0) && (i % 2 == 1));
          MODE_PWM:   led_nxt[i] = pwm_on;
          default:    led_nxt[i] = 1'b0;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      pwm_cnt   <= '0;
      duty      <= '0;
      dir       <= DIR_UP;
      mode_q    <= '0;
      led       <= '0;
    end else begin
      presc_cnt <= presc_nxt;
      blink_cnt <= blink_cnt_nxt;
      blink_ph  <= blink_ph_nxt;
      pwm_cnt   <= pwm_nxt;
      duty      <= duty_nxt;
      dir       <= dir_nxt;
      mode_q    <= mode_nxt;
      led       <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: a count-of-enabled-cycles reference model queues
// the expected LED word for each edge, which is popped and compared after it.
module tb_led_pattern_gen;

  localparam int NUM_CH     = 3;
  localparam int PRESCALE   = 4;
  localparam int BLINK_HALF = 2;
  localparam int PWM_BITS   = 2;
  localparam int STAGGER    = 1;
  localparam int DMAX       = (1 << PWM_BITS) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en  = 1'b1;
  logic [2*NUM_CH-1:0]   sel = '1;
  logic [NUM_CH-1:0]     led;
  logic                  tick;

  led_pattern_gen #(
    .NUM_CH(NUM_CH), .PRESCALE(PRESCALE), .BLINK_HALF(BLINK_HALF),
    .PWM_BITS(PWM_BITS), .STAGGER(STAGGER)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_pass   = 0;
  int               e        = 0;   // enabled, non-reset cycles since reset
  bit               valid    = 1'b0;
  logic [1:0]       mode_m [NUM_CH];
  logic [NUM_CH-1:0] exp_q [$];

  function automatic int tri_duty(input int ticks);
    int p;
    p = ticks % (2 * DMAX);
    return (p <= DMAX) ? p : 2 * DMAX - p;
  endfunction

  function automatic logic [NUM_CH-1:0] model_led();
    logic [NUM_CH-1:0] r;
    int ticks, ph, pwm;
    ticks = e / PRESCALE;
    ph    = (ticks / BLINK_HALF) % 2;
    pwm   = e % (1 << PWM_BITS);
    for (int i = 0; i < NUM_CH; i++) begin
      case (mode_m[i])
        2'b00:   r[i] = 1'b0;
        2'b01:   r[i] = 1'b1;
        2'b10:   r[i] = ph[0] ^ (STAGGER != 0 && (i % 2) == 1);
        default: r[i] = (pwm < tri_duty(ticks));
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
  endtask

  task automatic step(input logic r, input logic en_i, input logic [2*NUM_CH-1:0] s);
    logic [NUM_CH-1:0] expv;
    logic              tick_now;
    @(negedge clk);
    rst = r;
    en  = en_i;
    sel = s;
    #1;
    tick_now = en_i && (e % PRESCALE == PRESCALE - 1);
    if (valid) check("tick", 32'(tick), 32'(tick_now));
    if (r) begin
      expv = '0;
      e    = 0;
      for (int i = 0; i < NUM_CH; i++) mode_m[i] = 2'b00;
      valid = 1'b1;
    end else if (en_i) begin
      expv = model_led();
      if (tick_now) for (int i = 0; i < NUM_CH; i++) mode_m[i] = s[2*i +: 2];
      e++;
    end else begin
      expv = '0;
    end
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check("led", 32'(led), 32'(exp_q.pop_front()));
    else check("led_queue_underflow", 32'(exp_q.size()), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) mode_m[i] = 2'b00;

    // Reset held with everything requesting breathe.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 6'b111111);
    // All on, then all blink (ch1 in antiphase).
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 6'b010101);
    for (int k = 0; k < 22; k++) step(1'b0, 1'b1, 6'b101010);
    // Freeze mid-blink, then resume.
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 6'b101010);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 6'b101010);
    // Ch0 breathe over more than one full ramp period.
    for (int k = 0; k < 30; k++) step(1'b0, 1'b1, 6'b000011);
    // Change sel one cycle after a tick edge.
    for (int k = 0; k < 8; k++) begin
      if (e % PRESCALE == 1) break;
      step(1'b0, 1'b1, 6'b000011);
    end
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 6'b011001);
    // Random modes with occasional enable drops.
    for (int k = 0; k < 60; k++)
      step(1'b0, 1'($urandom_range(0, 7) != 0), 6'($urandom_range(0, 63)));
    // Breathe until duty reaches 2, then reset mid-ramp.
    for (int k = 0; k < 40; k++) begin
      if (tri_duty(e / PRESCALE) == 2 && (e / PRESCALE) % (2 * DMAX) > DMAX) break;
      step(1'b0, 1'b1, 6'b000011);
    end
    step(1'b1, 1'b1, 6'b000011);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 6'b000011);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
